i2c_cfg_responder: RTL and testbench

I2C_CFG_RESPONDER -- requirements
Module: i2c_cfg_responder

---
 rtl/i2c_pkg.sv | 14 +
 rtl/i2c_line_sync.sv | 37 +++
 rtl/i2c_cfg_responder.sv | 160 ++++++++++++++++
 tb/tb_i2c_cfg_responder.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared state encoding and constants for the I2C config responder
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE, DEV, DEV_ACK, B1, B1_ACK, B2, B2_ACK, IGNORE
  } i2c_state_e;

  localparam logic [6:0] REG_RESET_ADDR = 7'h0F;

  function automatic logic is_busy_state(input i2c_state_e s);
    return (s == DEV_ACK) || (s == B1) || (s == B1_ACK) || (s == B2) || (s == B2_ACK);
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// rtl/i2c_line_sync.sv - two-flop synchronizer plus history flop with edge detect
module i2c_line_sync (
  input  logic iCLK,
  input  logic iRST_N,
  input  logic line_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1_q, s2_q, hist_q;
  logic s1_d, s2_d, hist_d;

  always_comb begin
    s1_d   = line_in;
    s2_d   = s1_q;
    hist_d = s2_q;
  end

  // Reset to 1 so an idle (pulled-up) bus shows no spurious edges
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      hist_q <= 1'b1;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      hist_q <= hist_d;
    end
  end

  assign level = s2_q;
  assign rise  = s2_q & ~hist_q;
  assign fall  = ~s2_q & hist_q;

endmodule

// File: rtl/i2c_cfg_responder.sv
// rtl/i2c_cfg_responder.sv - write-only I2C slave holding a small bank of 9-bit config registers
module i2c_cfg_responder
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h1A,
  parameter int         NUM_REGS = 16
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       I2C_SCLK,
  inout  wire        I2C_SDAT,
  input  logic [3:0] iRD_ADDR,
  output logic [8:0] oRD_DATA,
  output logic       oWR_STB,
  output logic [6:0] oWR_ADDR,
  output logic [8:0] oWR_DATA,
  output logic       oBUSY
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_sync u_scl_sync (
    .iCLK(iCLK), .iRST_N(iRST_N), .line_in(I2C_SCLK),
    .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_line_sync u_sda_sync (
    .iCLK(iCLK), .iRST_N(iRST_N), .line_in(I2C_SDAT),
    .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
  );

  i2c_state_e                 state_q, state_d;
  logic [2:0]                 cnt_q, cnt_d;
  logic [7:0]                 shift_q, shift_d;
  logic [7:0]                 b1_q, b1_d;
  logic                       sda_oe_q, sda_oe_d;
  logic                       stb_q, stb_d;
  logic                       busy_q, busy_d;
  logic [6:0]                 wr_addr_q, wr_addr_d;
  logic [8:0]                 wr_data_q, wr_data_d;
  logic [NUM_REGS-1:0][8:0]   regs_q, regs_d;

  logic       start_det, stop_det;
  logic [6:0] reg_addr;
  logic [8:0] wr_val;

  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;
  assign reg_addr  = b1_q[7:1];
  assign wr_val    = {b1_q[0], shift_q};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    b1_d      = b1_q;
    sda_oe_d  = sda_oe_q;
    stb_d     = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    regs_d    = regs_q;
    if (start_det) begin
      state_d  = DEV;
      cnt_d    = 3'd0;
      sda_oe_d = 1'b0;
    end else if (stop_det) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
    end else begin
      case (state_q)
        DEV, B1, B2: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_lvl};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              case (state_q)
                DEV:     state_d = (shift_d == {DEV_ADDR, 1'b0}) ? DEV_ACK : IGNORE;
                B1:      begin b1_d = shift_d; state_d = B1_ACK; end
                default: state_d = B2_ACK;
              endcase
            end
          end
        end
        DEV_ACK, B1_ACK, B2_ACK: begin
          // First falling edge starts the ACK low phase, the second ends it
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              cnt_d    = 3'd0;
              case (state_q)
                DEV_ACK: state_d = B1;
                B1_ACK:  state_d = B2;
                default: begin
                  state_d = IGNORE;
                  if (reg_addr == REG_RESET_ADDR) begin
                    regs_d    = '0;
                    stb_d     = 1'b1;
                    wr_addr_d = reg_addr;
                    wr_data_d = wr_val;
                  end else if (32'(reg_addr) < NUM_REGS) begin
                    for (int i = 0; i < NUM_REGS; i++)
                      if (32'(reg_addr) == i) regs_d[i] = wr_val;
                    stb_d     = 1'b1;
                    wr_addr_d = reg_addr;
                    wr_data_d = wr_val;
                  end
                end
              endcase
            end
          end
        end
        default: ;
      endcase
    end
    busy_d = is_busy_state(state_d);
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q   <= IDLE;
      cnt_q     <= 3'd0;
      shift_q   <= 8'd0;
      b1_q      <= 8'd0;
      sda_oe_q  <= 1'b0;
      stb_q     <= 1'b0;
      busy_q    <= 1'b0;
      wr_addr_q <= 7'd0;
      wr_data_q <= 9'd0;
      regs_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      b1_q      <= b1_d;
      sda_oe_q  <= sda_oe_d;
      stb_q     <= stb_d;
      busy_q    <= busy_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      regs_q    <= regs_d;
    end
  end

  always_comb begin
    oRD_DATA = 9'd0;
    for (int i = 0; i < NUM_REGS; i++)
      if (32'(iRD_ADDR) == i) oRD_DATA = regs_q[i];
  end

  // Gating with iRST_N releases the bus the instant reset asserts
  assign I2C_SDAT = (sda_oe_q && iRST_N) ? 1'b0 : 1'bz;
  assign oWR_STB  = stb_q;
  assign oWR_ADDR = wr_addr_q;
  assign oWR_DATA = wr_data_q;
  assign oBUSY    = busy_q;

endmodule

// File: tb/tb_i2c_cfg_responder.sv
// tb/tb_i2c_cfg_responder.sv - self-checking bench for i2c_cfg_responder
module tb_i2c_cfg_responder;

  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       m_sda = 1'b1;
  logic [3:0] rd_addr = 4'd0;
  logic [8:0] rd_data, wr_data;
  logic [6:0] wr_addr;
  logic       wr_stb, busy;

  wire sda_bus;
  pullup (sda_bus);
  assign sda_bus = m_sda ? 1'bz : 1'b0;

  i2c_cfg_responder #(.DEV_ADDR(7'h1A), .NUM_REGS(16)) dut (
    .iCLK(clk), .iRST_N(rst_n), .I2C_SCLK(scl), .I2C_SDAT(sda_bus),
    .iRD_ADDR(rd_addr), .oRD_DATA(rd_data), .oWR_STB(wr_stb),
    .oWR_ADDR(wr_addr), .oWR_DATA(wr_data), .oBUSY(busy)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int stb_cnt = 0;
  int dut_low = 0;

  always @(negedge clk) begin
    if (wr_stb === 1'b1) stb_cnt++;
    if (m_sda && sda_bus === 1'b0) dut_low++;
  end

  logic [8:0] m_regs [16];
  logic [6:0] m_wr_addr;
  logic [8:0] m_wr_data;

  typedef struct {
    logic [7:0] b0, b1, b2;
    logic [2:0] ack;
    int         nstb;
    logic [3:0] rd;
    logic [8:0] rd_exp;
    logic [6:0] wa;
    logic [8:0] wd;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 9'd0;
    m_wr_addr = 7'd0;
    m_wr_data = 9'd0;
  endtask

  // Frame semantics: only the write byte 0x34 is answered; the word is addr=B1/2, data=(B1 odd)*256+B2
  task automatic model_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             output logic [2:0] acks, output int nstb);
    int addr, data;
    acks = 3'b000;
    nstb = 0;
    if (b0 == 8'h34) begin
      acks = 3'b111;
      addr = int'(b1) / 2;
      data = (int'(b1) % 2) * 256 + int'(b2);
      if (addr == 15) begin
        for (int i = 0; i < 16; i++) m_regs[i] = 9'd0;
        nstb = 1;
      end else if (addr < 16) begin
        m_regs[addr] = 9'(data);
        nstb = 1;
      end
      if (nstb == 1) begin
        m_wr_addr = 7'(addr);
        m_wr_data = 9'(data);
      end
    end
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      #1;
      chk($sformatf("%s_reg%0d", tag, i), 32'(rd_data), 32'(m_regs[i]));
    end
  endtask

  task automatic start_cond();
    m_sda = 1'b1; tick(Q);
    scl = 1'b1;   tick(Q);
    m_sda = 1'b0; tick(Q);
    scl = 1'b0;   tick(Q);
  endtask

  task automatic stop_cond();
    m_sda = 1'b0; tick(Q);
    scl = 1'b1;   tick(Q);
    m_sda = 1'b1; tick(Q);
  endtask

  task automatic send_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      m_sda = b[i]; tick(Q);
      scl = 1'b1;   tick(2 * Q);
      scl = 1'b0;   tick(Q);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    send_bits(b);
    m_sda = 1'b1; tick(Q);
    scl = 1'b1;   tick(Q);
    ack = (sda_bus === 1'b0);
    tick(Q);
    scl = 1'b0;   tick(Q);
  endtask

  task automatic do_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                          output logic [2:0] acks);
    logic a0, a1, a2;
    start_cond();
    send_byte(b0, a0);
    send_byte(b1, a1);
    send_byte(b2, a2);
    stop_cond();
    tick(4);
    acks = {a0, a1, a2};
  endtask

  vec_t vt [7];

  initial begin
    logic [2:0] acks, exp_acks;
    logic       a;
    int         nstb, s0, l0;
    logic [7:0] rb0, rb1, rb2;

    vt[0] = '{8'h34, 8'h00, 8'h1A, 3'b111, 1, 4'd0, 9'h01A, 7'h00, 9'h01A};
    vt[1] = '{8'h34, 8'h08, 8'hF8, 3'b111, 1, 4'd4, 9'h0F8, 7'h04, 9'h0F8};
    vt[2] = '{8'h34, 8'h05, 8'h00, 3'b111, 1, 4'd2, 9'h100, 7'h02, 9'h100};
    vt[3] = '{8'h40, 8'h15, 8'h00, 3'b000, 0, 4'd2, 9'h100, 7'h02, 9'h100};
    vt[4] = '{8'h34, 8'h1E, 8'h00, 3'b111, 1, 4'd0, 9'h000, 7'h0F, 9'h000};
    vt[5] = '{8'h34, 8'h40, 8'h55, 3'b111, 0, 4'd0, 9'h000, 7'h0F, 9'h000};
    vt[6] = '{8'h35, 8'h00, 8'h00, 3'b000, 0, 4'd0, 9'h000, 7'h0F, 9'h000};

    model_reset();
    tick(3);
    chk("rst_sda", 32'(sda_bus), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_stb", 32'(wr_stb), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    rst_n = 1'b1;
    tick(4);
    check_regs("rst");

    for (int k = 0; k < 7; k++) begin
      s0 = stb_cnt;
      l0 = dut_low;
      do_frame(vt[k].b0, vt[k].b1, vt[k].b2, acks);
      model_frame(vt[k].b0, vt[k].b1, vt[k].b2, exp_acks, nstb);
      chk($sformatf("vec%0d_ack", k), 32'(acks), 32'(vt[k].ack));
      chk($sformatf("vec%0d_stb", k), 32'(stb_cnt - s0), 32'(vt[k].nstb));
      chk($sformatf("vec%0d_wr_addr", k), 32'(wr_addr), 32'(vt[k].wa));
      chk($sformatf("vec%0d_wr_data", k), 32'(wr_data), 32'(vt[k].wd));
      chk($sformatf("vec%0d_busy", k), 32'(busy), 32'd0);
      rd_addr = vt[k].rd;
      #1;
      chk($sformatf("vec%0d_rd", k), 32'(rd_data), 32'(vt[k].rd_exp));
      if (vt[k].ack == 3'b000)
        chk($sformatf("vec%0d_no_drive", k), 32'(dut_low - l0), 32'd0);
      check_regs($sformatf("vec%0d", k));
    end

    // Extra byte after B2 is NACKed; busy is high once the device byte is acknowledged
    s0 = stb_cnt;
    start_cond();
    send_byte(8'h34, a);
    chk("busy_mid_frame", 32'(busy), 32'd1);
    send_byte(8'h02, a);
    send_byte(8'h33, a);
    chk("b2_ack", 32'(a), 32'd1);
    send_byte(8'h77, a);
    chk("extra_byte_nack", 32'(a), 32'd0);
    stop_cond();
    tick(4);
    model_frame(8'h34, 8'h02, 8'h33, exp_acks, nstb);
    chk("extra_byte_stb", 32'(stb_cnt - s0), 32'd1);
    check_regs("extra");

    // Partial word aborted by repeated START, then a full frame to register 6
    do_frame(8'h34, 8'h0D, 8'h55, acks);
    model_frame(8'h34, 8'h0D, 8'h55, exp_acks, nstb);
    s0 = stb_cnt;
    start_cond();
    send_byte(8'h34, a);
    send_byte(8'h0A, a);
    do_frame(8'h34, 8'h0C, 8'h00, acks);
    model_frame(8'h34, 8'h0C, 8'h00, exp_acks, nstb);
    chk("rstart_ack", 32'(acks), 32'b111);
    chk("rstart_stb", 32'(stb_cnt - s0), 32'd1);
    chk("rstart_wr_addr", 32'(wr_addr), 32'h06);
    check_regs("rstart");

    // Reset asserted while the B1 ACK is being driven
    start_cond();
    send_byte(8'h34, a);
    send_bits(8'h07);
    m_sda = 1'b1;
    tick(Q);
    chk("ack_low_before_rst", 32'(sda_bus), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rst_release_sda", 32'(sda_bus), 32'd1);
    tick(2);
    model_reset();
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_wr_addr", 32'(wr_addr), 32'd0);
    rst_n = 1'b1;
    tick(2);
    scl = 1'b1;
    tick(Q);
    check_regs("midrst");
    s0 = stb_cnt;
    do_frame(8'h34, 8'h03, 8'hAB, acks);
    model_frame(8'h34, 8'h03, 8'hAB, exp_acks, nstb);
    chk("post_rst_ack", 32'(acks), 32'b111);
    chk("post_rst_stb", 32'(stb_cnt - s0), 32'd1);
    chk("post_rst_wr_data", 32'(wr_data), 32'h1AB);
    check_regs("post_rst");

    for (int k = 0; k < 20; k++) begin
      rb0 = ($urandom_range(0, 3) != 0) ? 8'h34 : 8'($urandom_range(0, 255));
      rb1 = 8'(($urandom_range(0, 19) << 1) | $urandom_range(0, 1));
      rb2 = 8'($urandom_range(0, 255));
      s0 = stb_cnt;
      l0 = dut_low;
      do_frame(rb0, rb1, rb2, acks);
      model_frame(rb0, rb1, rb2, exp_acks, nstb);
      chk($sformatf("rnd%0d_ack", k), 32'(acks), 32'(exp_acks));
      chk($sformatf("rnd%0d_stb", k), 32'(stb_cnt - s0), 32'(nstb));
      chk($sformatf("rnd%0d_wr_addr", k), 32'(wr_addr), 32'(m_wr_addr));
      chk($sformatf("rnd%0d_wr_data", k), 32'(wr_data), 32'(m_wr_data));
      if (exp_acks == 3'b000)
        chk($sformatf("rnd%0d_no_drive", k), 32'(dut_low - l0), 32'd0);
      rd_addr = 4'($urandom_range(0, 15));
      #1;
      chk($sformatf("rnd%0d_rd", k), 32'(rd_data), 32'(m_regs[rd_addr]));
    end
    check_regs("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
